// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising memory controller: FSM states,
// requester identities, access-size codes and the byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    localparam logic [1:0] SelByte = 2'b00;
    localparam logic [1:0] SelHalf = 2'b01;
    localparam logic [1:0] SelWord = 2'b10;

    // Number of RAM bytes touched by one transaction; code 11 behaves as a word.
    function automatic logic [2:0] byte_count(input grant_t who, input logic [1:0] sel);
        logic [2:0] n;
        n = 3'd4;
        if (who == GNT_IF) begin
            n = 3'd4;
        end else begin
            case (sel)
                SelByte: n = 3'd1;
                SelHalf: n = 3'd2;
                SelWord: n = 3'd4;
                default: n = 3'd4;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and load/store requests onto a byte-wide RAM,
// serialising each access one byte per cycle in little-endian order.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din,
    output logic        stallreq_from_if,
    output logic        stallreq_from_mem
);

    state_t      state_r;
    state_t      state_s;
    grant_t      last_grant_r;
    logic [31:0] base_r;
    logic [31:0] wdata_r;
    logic [2:0]  cnt_r;
    logic [2:0]  n_r;
    logic [31:0] rd_buf_r;

    logic        accept_s;
    logic        pick_mem_s;
    grant_t      acc_grant_s;
    logic        acc_write_s;
    logic [31:0] acc_addr_s;
    logic [2:0]  acc_n_s;
    logic        last_rd_s;
    logic        last_wr_s;
    logic        more_addr_s;
    logic [31:0] next_addr_s;
    logic [1:0]  rd_idx_s;
    logic [1:0]  wr_idx_s;
    logic [31:0] rd_merge_s;
    logic [7:0]  wr_byte_s;

    assign stallreq_from_if  = if_req & ~if_done;
    assign stallreq_from_mem = mem_req & ~mem_done;

    // Arbitration and per-cycle datapath terms; MEM wins unless it also won last time.
    always_comb begin
        accept_s    = 1'b0;
        pick_mem_s  = 1'b0;
        acc_grant_s = GNT_IF;
        acc_write_s = 1'b0;
        acc_addr_s  = if_addr;
        if (state_r == ST_IDLE) begin
            accept_s = if_req | mem_req;
        end else begin
            accept_s = 1'b0;
        end
        if (mem_req && !(if_req && (last_grant_r == GNT_MEM))) begin
            pick_mem_s  = 1'b1;
            acc_grant_s = GNT_MEM;
            acc_write_s = mem_we;
            acc_addr_s  = mem_addr;
        end else begin
            pick_mem_s  = 1'b0;
            acc_grant_s = GNT_IF;
            acc_write_s = 1'b0;
            acc_addr_s  = if_addr;
        end
        acc_n_s     = byte_count(acc_grant_s, mem_sel);
        last_rd_s   = (state_r == ST_READ) && (cnt_r == n_r);
        last_wr_s   = (state_r == ST_WRITE) && (cnt_r == (n_r - 3'd1));
        more_addr_s = (cnt_r + 3'd1) < n_r;
        next_addr_s = base_r + {29'd0, cnt_r} + 32'd1;
        // Byte arriving now belongs to the address driven one cycle earlier.
        rd_idx_s    = cnt_r[1:0] - 2'd1;
        wr_idx_s    = cnt_r[1:0] + 2'd1;
        rd_merge_s  = rd_buf_r;
        rd_merge_s[{rd_idx_s, 3'b000} +: 8] = ram_din;
        wr_byte_s   = wdata_r[{wr_idx_s, 3'b000} +: 8];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = acc_write_s ? ST_WRITE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_rd_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (last_wr_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Latched request fields, byte sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= GNT_IF;
            base_r       <= 32'd0;
            wdata_r      <= 32'd0;
            cnt_r        <= 3'd0;
            n_r          <= 3'd0;
            rd_buf_r     <= 32'd0;
            ram_addr     <= 32'd0;
            ram_dout     <= 8'd0;
            ram_wr       <= 1'b0;
            if_data      <= 32'd0;
            if_done      <= 1'b0;
            mem_rdata    <= 32'd0;
            mem_done     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= acc_grant_s;
                        base_r       <= acc_addr_s;
                        wdata_r      <= pick_mem_s ? mem_wdata : 32'd0;
                        cnt_r        <= 3'd0;
                        n_r          <= acc_n_s;
                        rd_buf_r     <= 32'd0;
                        ram_addr     <= acc_addr_s;
                        ram_wr       <= acc_write_s;
                        ram_dout     <= acc_write_s ? mem_wdata[7:0] : 8'd0;
                    end else begin
                        ram_wr   <= 1'b0;
                        ram_dout <= 8'd0;
                    end
                end
                ST_READ: begin
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r != 3'd0) begin
                        rd_buf_r <= rd_merge_s;
                    end
                    if (more_addr_s) begin
                        ram_addr <= next_addr_s;
                    end
                    if (last_rd_s) begin
                        if (last_grant_r == GNT_MEM) begin
                            mem_rdata <= rd_merge_s;
                            mem_done  <= 1'b1;
                        end else begin
                            if_data <= rd_merge_s;
                            if_done <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (last_wr_s) begin
                        ram_wr   <= 1'b0;
                        ram_dout <= 8'd0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt_r    <= cnt_r + 3'd1;
                        ram_addr <= next_addr_s;
                        ram_dout <= wr_byte_s;
                    end
                end
                ST_DONE: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    ram_wr   <= 1'b0;
                    ram_dout <= 8'd0;
                end
                default: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    ram_wr   <= 1'b0;
                    ram_dout <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, per-cycle trace checks
// against expectations derived from transaction size, address and RAM contents.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic        stallreq_from_if;
    logic        stallreq_from_mem;

    int checks = 0;
    int failures = 0;
    bit last_mem = 1'b0;

    logic [7:0]  ram_mem [0:4095];
    bit          ram_init = 1'b0;
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = 32'd0;
    logic [7:0]  poke_data = 8'd0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
    );

    always #5 clk = ~clk;

    // Byte RAM that only decodes the low 12 address bits; read data lags address by a cycle.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= 8'(i * 7 + 3);
            ram_init <= 1'b1;
        end else begin
            ram_din <= ram_mem[ram_addr[11:0]];
            if (ram_wr) ram_mem[ram_addr[11:0]] <= ram_dout;
            if (poke_en) ram_mem[poke_addr[11:0]] <= poke_data;
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // One transaction, checked cycle by cycle from acceptance (cycle 0) to one cycle past done.
    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got);
        int n;
        int done_at;
        logic [31:0] exp_rd;
        logic [31:0] a;
        logic [7:0]  b;
        logic d_me, d_other, stall_me;
        n = is_if ? 4 : ((sel == 2'b00) ? 1 : ((sel == 2'b01) ? 2 : 4));
        done_at = we ? n : n + 1;
        exp_rd = 32'd0;
        got = 32'd0;
        if (!we) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                exp_rd[8*k +: 8] = ram_mem[a[11:0]];
            end
        end
        @(negedge clk);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wdata;
        end
        @(posedge clk); #1;
        if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
        mem_sel = 2'($urandom); mem_we = ~we;
        for (int c = 0; c <= done_at + 1; c++) begin
            d_me     = is_if ? if_done : mem_done;
            d_other  = is_if ? mem_done : if_done;
            stall_me = is_if ? stallreq_from_if : stallreq_from_mem;
            if (c < n) begin
                a = addr + 32'(c);
                checks++;
                if (ram_addr !== a) begin
                    failures++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", c, ram_addr, a);
                end
                checks++;
                if (ram_wr !== we) begin
                    failures++; $display("FAIL ram_wr cyc=%0d got=%b exp=%b", c, ram_wr, we);
                end
                if (we) begin
                    b = wdata[8*c +: 8];
                    checks++;
                    if (ram_dout !== b) begin
                        failures++; $display("FAIL ram_dout cyc=%0d got=%h exp=%h", c, ram_dout, b);
                    end
                end
            end else begin
                checks++;
                if (ram_wr !== 1'b0 || ram_dout !== 8'd0) begin
                    failures++; $display("FAIL ram_idle cyc=%0d got wr=%b dout=%h exp wr=0 dout=00", c, ram_wr, ram_dout);
                end
            end
            checks++;
            if (d_me !== (c == done_at)) begin
                failures++; $display("FAIL done_timing cyc=%0d got=%b exp=%b", c, d_me, (c == done_at));
            end
            checks++;
            if (d_other !== 1'b0) begin
                failures++; $display("FAIL other_done cyc=%0d got=%b exp=0", c, d_other);
            end
            if (c <= done_at) begin
                checks++;
                if (stall_me !== (c != done_at)) begin
                    failures++; $display("FAIL stallreq cyc=%0d got=%b exp=%b", c, stall_me, (c != done_at));
                end
            end
            if (c == done_at && !we) begin
                got = is_if ? if_data : mem_rdata;
                checks++;
                if (got !== exp_rd) begin
                    failures++; $display("FAIL read_data got=%h exp=%h", got, exp_rd);
                end
            end
            if (c == done_at) begin
                @(negedge clk);
                if_req = 1'b0; mem_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        last_mem = !is_if;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
        mem_sel = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_addr, ram_dout, ram_wr, if_data, if_done, mem_rdata, mem_done,
             stallreq_from_if, stallreq_from_mem} !== 109'd0) begin
            failures++; $display("FAIL reset_outputs got addr=%h dout=%h wr=%b ifd=%h mrd=%h exp=0",
                                 ram_addr, ram_dout, ram_wr, if_data, mem_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        last_mem = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] got;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        run_txn(1'b1, 1'b0, 2'b10, 32'h100, 32'd0, got);
        checks++;
        if (got !== 32'h44332211) begin
            failures++; $display("FAIL fetch_0x100 got=%h exp=44332211", got);
        end
    endtask

    task automatic test_store_word();
        logic [31:0] got;
        logic [31:0] seen;
        run_txn(1'b0, 1'b1, 2'b10, 32'h200, 32'hDEADBEEF, got);
        seen = {ram_mem[12'h203], ram_mem[12'h202], ram_mem[12'h201], ram_mem[12'h200]};
        checks++;
        if (seen !== 32'hDEADBEEF) begin
            failures++; $display("FAIL store_word_ram got=%h exp=deadbeef", seen);
        end
    endtask

    task automatic test_byte_load();
        logic [31:0] got;
        poke(32'h203, 8'h9A);
        run_txn(1'b0, 1'b0, 2'b00, 32'h203, 32'd0, got);
        checks++;
        if (got !== 32'h0000009A) begin
            failures++; $display("FAIL byte_load got=%h exp=0000009a", got);
        end
    endtask

    // Both requesters together; winner follows the alternation rule, loser is accepted right after DONE.
    task automatic test_pair(input logic [31:0] fa, input logic [31:0] ma);
        logic [31:0] exp_if, exp_mem, a;
        int if_at, mem_at;
        bit mem_first, saw_if, saw_mem;
        mem_first = !last_mem;
        for (int k = 0; k < 4; k++) begin
            a = fa + 32'(k); exp_if[8*k +: 8] = ram_mem[a[11:0]];
            a = ma + 32'(k); exp_mem[8*k +: 8] = ram_mem[a[11:0]];
        end
        if_at = -1; mem_at = -1;
        @(negedge clk);
        if_req = 1'b1; if_addr = fa;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 2'b10; mem_addr = ma;
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) begin
            saw_if = (if_done === 1'b1);
            saw_mem = (mem_done === 1'b1);
            if (saw_if) begin
                if_at = c; checks++;
                if (if_data !== exp_if) begin
                    failures++; $display("FAIL pair_if_data got=%h exp=%h", if_data, exp_if);
                end
            end
            if (saw_mem) begin
                mem_at = c; checks++;
                if (mem_rdata !== exp_mem) begin
                    failures++; $display("FAIL pair_mem_data got=%h exp=%h", mem_rdata, exp_mem);
                end
            end
            if (saw_if || saw_mem) begin
                @(negedge clk);
                if (saw_if) if_req = 1'b0;
                if (saw_mem) mem_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (if_at != (mem_first ? 12 : 5)) begin
            failures++; $display("FAIL pair_if_cycle got=%0d exp=%0d", if_at, mem_first ? 12 : 5);
        end
        checks++;
        if (mem_at != (mem_first ? 5 : 12)) begin
            failures++; $display("FAIL pair_mem_cycle got=%0d exp=%0d", mem_at, mem_first ? 5 : 12);
        end
        if_req = 1'b0; mem_req = 1'b0;
        last_mem = !mem_first;
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        run_txn(1'b1, 1'b0, 2'b10, 32'h040, 32'd0, got);
        test_pair(32'h080, 32'h0C0);
        run_txn(1'b0, 1'b0, 2'b00, 32'h010, 32'd0, got);
        test_pair(32'h180, 32'h1C0);
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        run_txn(1'b0, 1'b1, 2'b01, 32'hFFFFFFFF, 32'hCAFE1234, got);
        run_txn(1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'd0, got);
        checks++;
        if (got !== 32'h00001234) begin
            failures++; $display("FAIL wrap_half got=%h exp=00001234", got);
        end
    endtask

    // Reset during cycle 2 of a word access: everything drops at once and no done follows.
    task automatic test_reset_mid(input bit store);
        logic [31:0] got;
        @(negedge clk);
        if (store) begin
            mem_req = 1'b1; mem_we = 1'b1; mem_sel = 2'b10; mem_addr = 32'h340; mem_wdata = 32'h89ABCDEF;
        end else begin
            if_req = 1'b1; if_addr = 32'h300;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        if (store) begin
            checks++;
            if (ram_wr !== 1'b1) begin
                failures++; $display("FAIL pre_reset_wr got=%b exp=1", ram_wr);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_addr, ram_dout, ram_wr, if_data, if_done, mem_rdata, mem_done} !== 107'd0) begin
            failures++; $display("FAIL mid_reset got addr=%h dout=%h wr=%b ifd=%h mrd=%h exp=0",
                                 ram_addr, ram_dout, ram_wr, if_data, mem_rdata);
        end
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_mem = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if (if_done !== 1'b0 || mem_done !== 1'b0 || ram_wr !== 1'b0) begin
                failures++; $display("FAIL post_reset_quiet cyc=%0d got ifd=%b md=%b wr=%b exp=0", c, if_done, mem_done, ram_wr);
            end
        end
        run_txn(1'b1, 1'b0, 2'b10, 32'h300, 32'd0, got);
    endtask

    task automatic test_random(input int count);
        logic [31:0] got, addr;
        bit is_if, we;
        for (int t = 0; t < count; t++) begin
            is_if = bit'($urandom_range(0, 1));
            we = is_if ? 1'b0 : bit'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            run_txn(is_if, we, 2'($urandom), addr, $urandom, got);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_word();
        test_byte_load();
        test_back_to_back();
        test_wrap();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
